// File: rtl/core_pkg.sv
// Shared types and widths for the rename-to-dispatch path.
// Holds the buffered instruction format and the source wakeup helper.
package core_pkg;
  localparam int XLEN       = 32;
  localparam int ROB_W      = 4;
  localparam int FID_W      = 8;
  localparam int IMM_W      = 26;
  localparam int ALU_CMD_W  = 5;
  localparam int MUL_CMD_W  = 1;
  localparam int MEM_CMD_W  = 5;
  localparam int BRU_CMD_W  = 7;
  localparam int BAGU_CMD_W = 2;

  typedef struct packed {
    logic [1:0]      pattern;
    logic            taken;
    logic            hit;
    logic [XLEN-1:0] target;
  } bp_info_t;

  typedef struct packed {
    logic             ready;
    logic [ROB_W-1:0] rob;
    logic [XLEN-1:0]  value;
  } src_t;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [IMM_W-1:0]      imm;
    logic [FID_W-1:0]      fid;
    logic [ROB_W-1:0]      dst_rob;
    logic                  pipe_alu;
    logic                  pipe_mul;
    logic                  pipe_mem;
    logic                  pipe_bru;
    logic [ALU_CMD_W-1:0]  alu_cmd;
    logic [MUL_CMD_W-1:0]  mul_cmd;
    logic [MEM_CMD_W-1:0]  mem_cmd;
    logic [BRU_CMD_W-1:0]  bru_cmd;
    logic [BAGU_CMD_W-1:0] bagu_cmd;
    bp_info_t              bp;
    src_t                  src0;
    src_t                  src1;
  } iq_entry_t;

  function automatic src_t src_wakeup(input src_t s, input logic wb_valid,
                                      input logic [ROB_W-1:0] wb_rob,
                                      input logic [XLEN-1:0] wb_value);
    src_t r;
    r = s;
    if (!s.ready && wb_valid && (s.rob == wb_rob)) begin
      r.ready = 1'b1;
      r.value = wb_value;
    end
    return r;
  endfunction
endpackage

// File: rtl/issue_queue_entry.sv
// One issue-queue slot: valid bit, stored instruction, and per-source wakeup.
// Payload is left unreset; only the valid bit is cleared by reset or flush.
module issue_queue_entry
  import core_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  iq_entry_t        wr_data_i,
  input  logic             clr_i,
  input  logic             wb_valid_i,
  input  logic [ROB_W-1:0] wb_rob_i,
  input  logic [XLEN-1:0]  wb_value_i,
  output logic             vld_o,
  output iq_entry_t        data_o
);
  logic      valid_q, valid_d;
  iq_entry_t data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    if (!resetn || flush_i) valid_d = 1'b0;
    else if (wr_en_i)       valid_d = 1'b1;
    else if (clr_i)         valid_d = 1'b0;
  end

  // A writeback in the enqueue cycle is folded into the incoming sources.
  always_comb begin
    data_d = data_q;
    if (wr_en_i) begin
      data_d      = wr_data_i;
      data_d.src0 = src_wakeup(wr_data_i.src0, wb_valid_i, wb_rob_i, wb_value_i);
      data_d.src1 = src_wakeup(wr_data_i.src1, wb_valid_i, wb_rob_i, wb_value_i);
    end else if (valid_q) begin
      data_d.src0 = src_wakeup(data_q.src0, wb_valid_i, wb_rob_i, wb_value_i);
      data_d.src1 = src_wakeup(data_q.src1, wb_valid_i, wb_rob_i, wb_value_i);
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    data_q  <= data_d;
  end

  assign vld_o  = valid_q;
  assign data_o = data_q;
endmodule

// File: rtl/issue_queue.sv
// In-order issue buffer ahead of dispatch: circular queue of DEPTH entries,
// head issues once both sources are ready or forwardable from the last ALU issue.
module issue_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        bco_valid,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_pc,
  input  logic [25:0] i_imm,
  input  logic [7:0]  i_fid,
  input  logic [3:0]  i_dst_rob,
  input  logic        i_pipe_alu,
  input  logic        i_pipe_mul,
  input  logic        i_pipe_mem,
  input  logic        i_pipe_bru,
  input  logic [4:0]  i_alu_cmd,
  input  logic        i_mul_cmd,
  input  logic [4:0]  i_mem_cmd,
  input  logic [6:0]  i_bru_cmd,
  input  logic [1:0]  i_bagu_cmd,
  input  logic [1:0]  i_bp_pattern,
  input  logic        i_bp_taken,
  input  logic        i_bp_hit,
  input  logic [31:0] i_bp_target,
  input  logic        i_src0_ready,
  input  logic [3:0]  i_src0_rob,
  input  logic [31:0] i_src0_value,
  input  logic        i_src1_ready,
  input  logic [3:0]  i_src1_rob,
  input  logic [31:0] i_src1_value,
  input  logic        i_wb_valid,
  input  logic [3:0]  i_wb_rob,
  input  logic [31:0] i_wb_value,
  input  logic        i_issue_en,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [25:0] o_imm,
  output logic [7:0]  o_fid,
  output logic [3:0]  o_dst_rob,
  output logic        o_pipe_alu,
  output logic        o_pipe_mul,
  output logic        o_pipe_mem,
  output logic        o_pipe_bru,
  output logic [4:0]  o_alu_cmd,
  output logic        o_mul_cmd,
  output logic [4:0]  o_mem_cmd,
  output logic [6:0]  o_bru_cmd,
  output logic [1:0]  o_bagu_cmd,
  output logic [1:0]  o_bp_pattern,
  output logic        o_bp_taken,
  output logic        o_bp_hit,
  output logic [31:0] o_bp_target,
  output logic [31:0] o_src0_value,
  output logic        o_src0_forward_alu,
  output logic [31:0] o_src1_value,
  output logic        o_src1_forward_alu
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic             last_alu_valid_q, last_alu_valid_d;
  logic [ROB_W-1:0] last_alu_rob_q, last_alu_rob_d;
  logic [IDX_W-1:0] head_idx, tail_idx;
  logic             full, enq;
  logic [DEPTH-1:0] ent_vld;
  iq_entry_t        ent_data [DEPTH];
  iq_entry_t        wr_data, head;
  logic             src0_fwd, src1_fwd, src0_ok, src1_ok;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];
  assign full     = (head_q[IDX_W] != tail_q[IDX_W]) && (head_idx == tail_idx);
  assign o_ready  = !full;
  assign enq      = resetn && i_valid && !full && !bco_valid;

  always_comb begin
    wr_data             = '0;
    wr_data.pc          = i_pc;
    wr_data.imm         = i_imm;
    wr_data.fid         = i_fid;
    wr_data.dst_rob     = i_dst_rob;
    wr_data.pipe_alu    = i_pipe_alu;
    wr_data.pipe_mul    = i_pipe_mul;
    wr_data.pipe_mem    = i_pipe_mem;
    wr_data.pipe_bru    = i_pipe_bru;
    wr_data.alu_cmd     = i_alu_cmd;
    wr_data.mul_cmd     = i_mul_cmd;
    wr_data.mem_cmd     = i_mem_cmd;
    wr_data.bru_cmd     = i_bru_cmd;
    wr_data.bagu_cmd    = i_bagu_cmd;
    wr_data.bp.pattern  = i_bp_pattern;
    wr_data.bp.taken    = i_bp_taken;
    wr_data.bp.hit      = i_bp_hit;
    wr_data.bp.target   = i_bp_target;
    wr_data.src0.ready  = i_src0_ready;
    wr_data.src0.rob    = i_src0_rob;
    wr_data.src0.value  = i_src0_value;
    wr_data.src1.ready  = i_src1_ready;
    wr_data.src1.rob    = i_src1_rob;
    wr_data.src1.value  = i_src1_value;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    issue_queue_entry u_ent (
      .clk        (clk),
      .resetn     (resetn),
      .flush_i    (bco_valid),
      .wr_en_i    (enq && (tail_idx == IDX_W'(g))),
      .wr_data_i  (wr_data),
      .clr_i      (o_valid && (head_idx == IDX_W'(g))),
      .wb_valid_i (i_wb_valid),
      .wb_rob_i   (i_wb_rob),
      .wb_value_i (i_wb_value),
      .vld_o      (ent_vld[g]),
      .data_o     (ent_data[g])
    );
  end

  assign head = ent_data[head_idx];

  // Forwarding is only honoured for a source that writeback has not yet resolved.
  assign src0_fwd = !head.src0.ready && last_alu_valid_q && (head.src0.rob == last_alu_rob_q);
  assign src1_fwd = !head.src1.ready && last_alu_valid_q && (head.src1.rob == last_alu_rob_q);
  assign src0_ok  = head.src0.ready || src0_fwd;
  assign src1_ok  = head.src1.ready || src1_fwd;
  assign o_valid  = resetn && ent_vld[head_idx] && i_issue_en && !bco_valid && src0_ok && src1_ok;

  always_comb begin
    head_d           = head_q + PTR_W'(o_valid);
    tail_d           = tail_q + PTR_W'(enq);
    last_alu_valid_d = o_valid && head.pipe_alu;
    last_alu_rob_d   = head.dst_rob;
    if (!resetn || bco_valid) begin
      head_d           = '0;
      tail_d           = '0;
      last_alu_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    head_q           <= head_d;
    tail_q           <= tail_d;
    last_alu_valid_q <= last_alu_valid_d;
    last_alu_rob_q   <= last_alu_rob_d;
  end

  assign o_pc               = head.pc;
  assign o_imm              = head.imm;
  assign o_fid              = head.fid;
  assign o_dst_rob          = head.dst_rob;
  assign o_pipe_alu         = head.pipe_alu;
  assign o_pipe_mul         = head.pipe_mul;
  assign o_pipe_mem         = head.pipe_mem;
  assign o_pipe_bru         = head.pipe_bru;
  assign o_alu_cmd          = head.alu_cmd;
  assign o_mul_cmd          = head.mul_cmd;
  assign o_mem_cmd          = head.mem_cmd;
  assign o_bru_cmd          = head.bru_cmd;
  assign o_bagu_cmd         = head.bagu_cmd;
  assign o_bp_pattern       = head.bp.pattern;
  assign o_bp_taken         = head.bp.taken;
  assign o_bp_hit           = head.bp.hit;
  assign o_bp_target        = head.bp.target;
  assign o_src0_value       = src0_fwd ? '0 : head.src0.value;
  assign o_src0_forward_alu = src0_fwd;
  assign o_src1_value       = src1_fwd ? '0 : head.src1.value;
  assign o_src1_forward_alu = src1_fwd;
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: expected issues are queued at enqueue time
// and popped/compared whenever the DUT presents o_valid.
module tb_issue_queue;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        bco_valid = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_pc = '0;
  logic [25:0] i_imm = '0;
  logic [7:0]  i_fid = '0;
  logic [3:0]  i_dst_rob = '0;
  logic        i_pipe_alu = 1'b0, i_pipe_mul = 1'b0, i_pipe_mem = 1'b0, i_pipe_bru = 1'b0;
  logic [4:0]  i_alu_cmd = '0;
  logic        i_mul_cmd = 1'b0;
  logic [4:0]  i_mem_cmd = '0;
  logic [6:0]  i_bru_cmd = '0;
  logic [1:0]  i_bagu_cmd = '0;
  logic [1:0]  i_bp_pattern = '0;
  logic        i_bp_taken = 1'b0, i_bp_hit = 1'b0;
  logic [31:0] i_bp_target = '0;
  logic        i_src0_ready = 1'b0;
  logic [3:0]  i_src0_rob = '0;
  logic [31:0] i_src0_value = '0;
  logic        i_src1_ready = 1'b0;
  logic [3:0]  i_src1_rob = '0;
  logic [31:0] i_src1_value = '0;
  logic        i_wb_valid = 1'b0;
  logic [3:0]  i_wb_rob = '0;
  logic [31:0] i_wb_value = '0;
  logic        i_issue_en = 1'b0;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [25:0] o_imm;
  logic [7:0]  o_fid;
  logic [3:0]  o_dst_rob;
  logic        o_pipe_alu, o_pipe_mul, o_pipe_mem, o_pipe_bru;
  logic [4:0]  o_alu_cmd;
  logic        o_mul_cmd;
  logic [4:0]  o_mem_cmd;
  logic [6:0]  o_bru_cmd;
  logic [1:0]  o_bagu_cmd;
  logic [1:0]  o_bp_pattern;
  logic        o_bp_taken, o_bp_hit;
  logic [31:0] o_bp_target;
  logic [31:0] o_src0_value, o_src1_value;
  logic        o_src0_forward_alu, o_src1_forward_alu;

  issue_queue #(.DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .bco_valid(bco_valid), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_imm(i_imm), .i_fid(i_fid), .i_dst_rob(i_dst_rob),
    .i_pipe_alu(i_pipe_alu), .i_pipe_mul(i_pipe_mul), .i_pipe_mem(i_pipe_mem), .i_pipe_bru(i_pipe_bru),
    .i_alu_cmd(i_alu_cmd), .i_mul_cmd(i_mul_cmd), .i_mem_cmd(i_mem_cmd), .i_bru_cmd(i_bru_cmd),
    .i_bagu_cmd(i_bagu_cmd), .i_bp_pattern(i_bp_pattern), .i_bp_taken(i_bp_taken), .i_bp_hit(i_bp_hit),
    .i_bp_target(i_bp_target), .i_src0_ready(i_src0_ready), .i_src0_rob(i_src0_rob),
    .i_src0_value(i_src0_value), .i_src1_ready(i_src1_ready), .i_src1_rob(i_src1_rob),
    .i_src1_value(i_src1_value), .i_wb_valid(i_wb_valid), .i_wb_rob(i_wb_rob), .i_wb_value(i_wb_value),
    .i_issue_en(i_issue_en), .o_valid(o_valid), .o_pc(o_pc), .o_imm(o_imm), .o_fid(o_fid),
    .o_dst_rob(o_dst_rob), .o_pipe_alu(o_pipe_alu), .o_pipe_mul(o_pipe_mul), .o_pipe_mem(o_pipe_mem),
    .o_pipe_bru(o_pipe_bru), .o_alu_cmd(o_alu_cmd), .o_mul_cmd(o_mul_cmd), .o_mem_cmd(o_mem_cmd),
    .o_bru_cmd(o_bru_cmd), .o_bagu_cmd(o_bagu_cmd), .o_bp_pattern(o_bp_pattern), .o_bp_taken(o_bp_taken),
    .o_bp_hit(o_bp_hit), .o_bp_target(o_bp_target), .o_src0_value(o_src0_value),
    .o_src0_forward_alu(o_src0_forward_alu), .o_src1_value(o_src1_value),
    .o_src1_forward_alu(o_src1_forward_alu)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  fid;
    logic [3:0]  dst;
    logic [31:0] v0;
    logic        f0;
    logic [31:0] v1;
    logic        f1;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] fid, input logic [3:0] dst, input logic [31:0] v0,
                      input logic f0, input logic [31:0] v1, input logic f1, input int c);
    exp_t e;
    e.fid = fid; e.dst = dst; e.v0 = v0; e.f0 = f0; e.v1 = v1; e.f1 = f1; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic set_enq(input logic [7:0] fid, input logic alu, input logic [3:0] dst,
                         input logic r0, input logic [3:0] rob0, input logic [31:0] v0,
                         input logic r1, input logic [3:0] rob1, input logic [31:0] v1);
    i_valid      = 1'b1;
    i_pc         = 32'h1000 + 32'(fid) * 4;
    i_imm        = 26'(fid);
    i_fid        = fid;
    i_dst_rob    = dst;
    i_pipe_alu   = alu;
    i_pipe_mul   = 1'b0;
    i_pipe_mem   = 1'b0;
    i_pipe_bru   = !alu;
    i_alu_cmd    = fid[4:0];
    i_mul_cmd    = fid[0];
    i_mem_cmd    = fid[5:1];
    i_bru_cmd    = fid[6:0];
    i_bagu_cmd   = fid[1:0];
    i_bp_pattern = ~fid[1:0];
    i_bp_taken   = fid[0];
    i_bp_hit     = fid[1];
    i_bp_target  = ~(32'h1000 + 32'(fid) * 4);
    i_src0_ready = r0; i_src0_rob = rob0; i_src0_value = v0;
    i_src1_ready = r1; i_src1_rob = rob1; i_src1_value = v1;
  endtask

  task automatic set_wb(input logic [3:0] rob, input logic [31:0] v);
    i_wb_valid = 1'b1; i_wb_rob = rob; i_wb_value = v;
  endtask

  // One clock: sample at negedge, scoreboard any issue, then clear single-cycle pulses.
  task automatic cyc(input int exp_ready, input int exp_valid);
    exp_t e;
    @(negedge clk);
    if (exp_ready >= 0) chk("o_ready", 32'(o_ready), 32'(exp_ready));
    if (exp_valid >= 0) chk("o_valid", 32'(o_valid), 32'(exp_valid));
    if (o_valid) begin
      if (sb.size() == 0) begin
        chk("issue_not_expected", 32'(o_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("fid", 32'(o_fid), 32'(e.fid));
        chk("pc", o_pc, 32'h1000 + 32'(e.fid) * 4);
        chk("bp_target", o_bp_target, ~(32'h1000 + 32'(e.fid) * 4));
        chk("alu_cmd", 32'(o_alu_cmd), 32'(e.fid[4:0]));
        chk("dst_rob", 32'(o_dst_rob), 32'(e.dst));
        chk("src0_value", o_src0_value, e.v0);
        chk("src0_fwd", 32'(o_src0_forward_alu), 32'(e.f0));
        chk("src1_value", o_src1_value, e.v1);
        chk("src1_fwd", 32'(o_src1_forward_alu), 32'(e.f1));
        if (e.cyc >= 0) chk("issue_cycle", 32'(cyc_cnt), 32'(e.cyc));
      end
    end
    @(posedge clk);
    cyc_cnt++;
    #1;
    i_valid = 1'b0;
    i_wb_valid = 1'b0;
    bco_valid = 1'b0;
  endtask

  initial begin
    int base;
    logic [7:0] f;

    // Reset
    cyc(-1, -1);
    cyc(-1, -1);
    resetn = 1'b1;
    cyc(1, 0);

    // Four ready instructions back to back, each issuing the cycle after enqueue
    i_issue_en = 1'b1;
    base = cyc_cnt;
    for (int k = 0; k < 4; k++) begin
      f = 8'(1 + k);
      set_enq(f, 1'b0, 4'(8 + k), 1'b1, 4'd0, 32'(f) * 16, 1'b1, 4'd0, 32'(f) * 256 + 1);
      push(f, 4'(8 + k), 32'(f) * 16, 1'b0, 32'(f) * 256 + 1, 1'b0, base + k + 1);
      cyc(1, -1);
    end
    cyc(1, 1);

    // Writeback wakeup of a stored source
    base = cyc_cnt;
    set_enq(8'd10, 1'b0, 4'd9, 1'b0, 4'd5, 32'h0, 1'b1, 4'd0, 32'h11);
    cyc(1, 0);
    cyc(1, 0);
    cyc(1, 0);
    set_wb(4'd5, 32'hDEADBEEF);
    push(8'd10, 4'd9, 32'hDEADBEEF, 1'b0, 32'h11, 1'b0, base + 4);
    cyc(1, 0);
    cyc(1, 1);

    // Writeback in the same cycle as enqueue
    base = cyc_cnt;
    set_enq(8'd11, 1'b0, 4'd9, 1'b0, 4'd6, 32'h0, 1'b1, 4'd0, 32'h22);
    set_wb(4'd6, 32'h66);
    push(8'd11, 4'd9, 32'h66, 1'b0, 32'h22, 1'b0, base + 1);
    cyc(1, 0);
    cyc(1, 1);

    // ALU forward to a dependent at the head the very next cycle
    base = cyc_cnt;
    set_enq(8'd20, 1'b1, 4'd3, 1'b1, 4'd0, 32'hA0, 1'b1, 4'd0, 32'hA1);
    push(8'd20, 4'd3, 32'hA0, 1'b0, 32'hA1, 1'b0, base + 1);
    cyc(1, 0);
    set_enq(8'd21, 1'b0, 4'd9, 1'b1, 4'd0, 32'hB0, 1'b0, 4'd3, 32'h0);
    push(8'd21, 4'd9, 32'hB0, 1'b0, 32'h0, 1'b1, base + 2);
    cyc(1, 1);
    cyc(1, 1);

    // Forward window broken by one stalled cycle; consumer waits for writeback
    base = cyc_cnt;
    set_enq(8'd22, 1'b1, 4'd3, 1'b1, 4'd0, 32'hA2, 1'b1, 4'd0, 32'hA3);
    push(8'd22, 4'd3, 32'hA2, 1'b0, 32'hA3, 1'b0, base + 1);
    cyc(1, 0);
    set_enq(8'd23, 1'b0, 4'd9, 1'b1, 4'd0, 32'hC0, 1'b0, 4'd3, 32'h0);
    cyc(1, 1);
    i_issue_en = 1'b0;
    cyc(1, 0);
    i_issue_en = 1'b1;
    cyc(1, 0);
    set_wb(4'd3, 32'h333);
    push(8'd23, 4'd9, 32'hC0, 1'b0, 32'h333, 1'b0, base + 5);
    cyc(1, 0);
    cyc(1, 1);

    // Fill to full, then issue with a blocked enqueue, then wrap the pointers
    i_issue_en = 1'b0;
    base = cyc_cnt;
    for (int k = 0; k < 4; k++) begin
      f = 8'(30 + k);
      set_enq(f, 1'b0, 4'd1, 1'b1, 4'd0, 32'(f), 1'b1, 4'd0, ~32'(f));
      push(f, 4'd1, 32'(f), 1'b0, ~32'(f), 1'b0, base + 4 + k);
      cyc(1, 0);
    end
    i_issue_en = 1'b1;
    set_enq(8'd34, 1'b0, 4'd1, 1'b1, 4'd0, 32'd34, 1'b1, 4'd0, 32'd34);
    cyc(0, 1);
    for (int k = 0; k < 10; k++) begin
      f = 8'(40 + k);
      set_enq(f, 1'b0, 4'd2, 1'b1, 4'd0, 32'(f) + 7, 1'b1, 4'd0, 32'(f) + 9);
      push(f, 4'd2, 32'(f) + 7, 1'b0, 32'(f) + 9, 1'b0, base + 8 + k);
      cyc(1, 1);
    end
    for (int k = 0; k < 4; k++) cyc(1, -1);

    // Flush with concurrent enqueue and writeback
    i_issue_en = 1'b0;
    set_enq(8'd50, 1'b0, 4'd1, 1'b0, 4'd7, 32'h0, 1'b1, 4'd0, 32'h50);
    cyc(1, 0);
    set_enq(8'd51, 1'b0, 4'd1, 1'b1, 4'd0, 32'h51, 1'b1, 4'd0, 32'h51);
    cyc(1, 0);
    set_enq(8'd52, 1'b0, 4'd1, 1'b1, 4'd0, 32'h52, 1'b1, 4'd0, 32'h52);
    cyc(1, 0);
    i_issue_en = 1'b1;
    bco_valid = 1'b1;
    set_enq(8'd53, 1'b0, 4'd1, 1'b1, 4'd0, 32'h53, 1'b1, 4'd0, 32'h53);
    set_wb(4'd7, 32'h77);
    cyc(-1, 0);
    cyc(1, 0);
    cyc(1, 0);
    base = cyc_cnt;
    set_enq(8'd54, 1'b0, 4'd1, 1'b1, 4'd0, 32'h54, 1'b1, 4'd0, 32'h55);
    push(8'd54, 4'd1, 32'h54, 1'b0, 32'h55, 1'b0, base + 1);
    cyc(1, 0);
    cyc(1, 1);

    // Reset asserted mid-operation overrides enqueue and issue
    i_issue_en = 1'b0;
    set_enq(8'd60, 1'b0, 4'd1, 1'b1, 4'd0, 32'h60, 1'b1, 4'd0, 32'h60);
    cyc(1, 0);
    set_enq(8'd61, 1'b0, 4'd1, 1'b1, 4'd0, 32'h61, 1'b1, 4'd0, 32'h61);
    cyc(1, 0);
    i_issue_en = 1'b1;
    resetn = 1'b0;
    set_enq(8'd62, 1'b0, 4'd1, 1'b1, 4'd0, 32'h62, 1'b1, 4'd0, 32'h62);
    cyc(-1, 0);
    resetn = 1'b1;
    cyc(1, 0);
    cyc(1, 0);
    base = cyc_cnt;
    set_enq(8'd63, 1'b0, 4'd2, 1'b1, 4'd0, 32'h63, 1'b1, 4'd0, 32'h64);
    push(8'd63, 4'd2, 32'h63, 1'b0, 32'h64, 1'b0, base + 1);
    cyc(1, 0);
    cyc(1, 1);
    cyc(1, 0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
